// File: rtl/pixel_line_pingpong.sv
// rtl/pixel_line_pingpong.sv - double-banked line buffer, packed word writes, one pixel per clock reads
// Optional horizontal pixel doubling: define PIXEL_LINE_HDOUBLE_EN to add the hdouble input.

module pixel_line_pingpong #(
   parameter int BPP         = 4,
   parameter int WORD_PIXELS = 16,
   parameter int LINE_WORDS  = 128,
   localparam int WA = $clog2(LINE_WORDS),
   localparam int PA = $clog2(LINE_WORDS*WORD_PIXELS)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [WA-1:0]              wr_addr,
   input  logic [BPP*WORD_PIXELS-1:0] wr_data,
   input  logic                       wr_commit,
   output logic                       wr_ready,
   input  logic                       rd_start,
   output logic [BPP-1:0]             pixel,
   output logic                       pixel_valid,
   output logic                       line_done,
   output logic                       overrun,
   output logic                       underrun
`ifdef PIXEL_LINE_HDOUBLE_EN
   ,
   input  logic                       hdouble
`endif
);

   localparam int SW = $clog2(WORD_PIXELS);
   localparam int DW = BPP*WORD_PIXELS;
   localparam logic [PA-1:0] LAST_IDX = PA'(LINE_WORDS*WORD_PIXELS-1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t          state_q, state_d;
   logic [1:0]      full_q;
   logic            fill_bank_q;
   logic            play_bank_q;
   logic [PA-1:0]   pix_idx_q;
   logic            accept;
   logic            step;
   logic            release_line;
   logic [DW-1:0]   rd_word;
   logic [BPP-1:0]  rd_pix;
   logic [DW-1:0]   mem [0:2*LINE_WORDS-1];

`ifdef PIXEL_LINE_HDOUBLE_EN
   logic            dbl_q;
   logic            phase_q;
`endif

   // A bank is free for filling only while the fill pointer targets an uncommitted bank
   assign wr_ready = !full_q[fill_bank_q];

   // Word addressed by the current pixel index in the bank being displayed
   assign rd_word = mem[{play_bank_q, pix_idx_q[PA-1:SW]}];
   assign rd_pix  = rd_word[pix_idx_q[SW-1:0]*BPP +: BPP];

   // Read FSM next state; step marks cycles where the pixel index advances
   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      step         = 1'b0;
      release_line = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_start && full_q[play_bank_q]) begin
               accept  = 1'b1;
               state_d = STREAM;
            end
         end
         STREAM: begin
`ifdef PIXEL_LINE_HDOUBLE_EN
            step = !dbl_q || phase_q;
`else
            step = 1'b1;
`endif
            if (step && (pix_idx_q == LAST_IDX)) begin
               release_line = 1'b1;
               state_d      = IDLE;
            end
         end
      endcase
   end

   // Read FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Bank bookkeeping; commit and release always target different banks so both may apply
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_q      <= 2'b00;
         fill_bank_q <= 1'b0;
         play_bank_q <= 1'b0;
         pix_idx_q   <= '0;
      end else begin
         if (wr_commit && wr_ready) begin
            full_q[fill_bank_q] <= 1'b1;
            fill_bank_q         <= !fill_bank_q;
         end
         if (release_line) begin
            full_q[play_bank_q] <= 1'b0;
            play_bank_q         <= !play_bank_q;
         end
         if (accept)    pix_idx_q <= '0;
         else if (step) pix_idx_q <= pix_idx_q + 1'b1;
      end
   end

`ifdef PIXEL_LINE_HDOUBLE_EN
   // Doubling mode is latched per line; phase selects first or repeated presentation of a pixel
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dbl_q   <= 1'b0;
         phase_q <= 1'b0;
      end else if (accept) begin
         dbl_q   <= hdouble;
         phase_q <= 1'b0;
      end else if (state_q == STREAM) begin
         phase_q <= dbl_q && !phase_q;
      end
   end
`endif

   // Line storage; contents are deliberately not reset, the same-cycle write lands before commit moves the pointer
   always_ff @(posedge clk) begin
      if (wr_en && wr_ready) mem[{fill_bank_q, wr_addr}] <= wr_data;
   end

   // Registered outputs: one cycle behind the index, pixel forced to zero when not streaming
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixel       <= '0;
         pixel_valid <= 1'b0;
         line_done   <= 1'b0;
         overrun     <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         pixel       <= (state_q == STREAM) ? rd_pix : '0;
         pixel_valid <= (state_q == STREAM);
         line_done   <= release_line;
         overrun     <= (wr_en || wr_commit) && !wr_ready;
         underrun    <= (state_q == IDLE) && rd_start && !full_q[play_bank_q];
      end
   end

endmodule
